wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone classic arbiter with an ack watchdog.
//
// Merges the CPU instruction port (m0) and data port (m1) onto one RAM slave bus.
// The grant is held for a whole bus cycle (cyc high). A granted strobe that sees no
// s_ack for TIMEOUT cycles gets a one-cycle err pulse. The bus then drains until
// the master drops cyc.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   m0_* / m1_*         master ports (addr, wdata, sel, we, cyc, stb in; rdata, ack, err out)
//   s_*                 slave port (addr, wdata, sel, we, cyc, stb out; rdata, ack in)
//
// Build option:
//   WB_ARB_ROUND_ROBIN_EN  defined: a simultaneous request goes to the master not granted
//                          last. Undefined: m1 always wins.
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StDrain} state_e;

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          own_q, own_d;     // granted master, kept so DRAIN knows whom to wait for
  logic [CW-1:0] wdog_q, wdog_d;

  logic        gsel;               // 1 when m1 is the current/draining owner
  logic        g_cyc, g_stb;
  logic        ack_route, err_route;
  logic        pick;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign gsel  = (state_q == StGnt1) || ((state_q == StDrain) && own_q);
  assign g_cyc = gsel ? m1_cyc : m0_cyc;
  assign g_stb = gsel ? m1_stb : m0_stb;

  // Arbitration choice for IDLE when both masters request.
`ifdef WB_ARB_ROUND_ROBIN_EN
  assign pick = (m0_cyc && m1_cyc) ? ~last_gnt_q : m1_cyc;
`else
  assign pick = m1_cyc;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    own_d      = own_q;
    wdog_d     = wdog_q;
    ack_route  = 1'b0;
    err_route  = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_sel      = '0;
    s_we       = 1'b0;
    s_cyc      = 1'b0;
    s_stb      = 1'b0;

    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (m0_cyc || m1_cyc) begin
          own_d   = pick;
          state_d = pick ? StGnt1 : StGnt0;
        end
      end
      StGnt0, StGnt1: begin
        s_addr    = gsel ? m1_addr  : m0_addr;
        s_wdata   = gsel ? m1_wdata : m0_wdata;
        s_sel     = gsel ? m1_sel   : m0_sel;
        s_we      = gsel ? m1_we    : m0_we;
        s_cyc     = g_cyc;
        s_stb     = g_stb;
        ack_route = s_ack;
        if (!g_cyc) begin
          state_d    = StIdle;
          last_gnt_d = gsel;
          wdog_d     = '0;
        end else if (g_stb && !s_ack) begin
          // An ack in the expiry cycle takes the other branch, so ack wins.
          if (wdog_q == CW'(TIMEOUT - 1)) begin
            err_route = 1'b1;
            state_d   = StDrain;
            wdog_d    = '0;
          end else begin
            wdog_d = wdog_q + CW'(1);
          end
        end else begin
          wdog_d = '0;
        end
      end
      StDrain: begin
        if (!g_cyc) begin
          state_d    = StIdle;
          last_gnt_d = gsel;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m0_ack = ack_route && !gsel;
  assign m1_ack = ack_route && gsel;
  assign m0_err = err_route && !gsel;
  assign m1_err = err_route && gsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b0;
      own_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      own_q      <= own_d;
      wdog_q     <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(16), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_grant_addr [4];

  initial begin
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_grant_addr = '{32'hB0, 32'hA0, 32'hB0, 32'hA0};
`else
    exp_grant_addr = '{32'hB0, 32'hB0, 32'hB0, 32'hB0};
`endif
    rst_n = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    s_rdata = '0; s_ack = 0;
    #3;
    chk("reset_s_cyc", 32'(s_cyc), 0);
    chk("reset_s_addr", s_addr, 0);
    chk("reset_m0_ack", 32'(m0_ack), 0);
    chk("reset_m1_err", 32'(m1_err), 0);
    #9 rst_n = 1'b1;
    tick();

    // Single read from m0, slave acks on the third stb cycle.
    m0_addr = 32'h100; m0_cyc = 1; m0_stb = 1;
    #1 chk("rd_arb_cycle_s_cyc", 32'(s_cyc), 0);
    tick();
    chk("rd_s_cyc", 32'(s_cyc), 1);
    chk("rd_s_addr", s_addr, 32'h100);
    tick();
    tick();
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m0_ack", 32'(m0_ack), 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_ack", 32'(m1_ack), 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("rd_m0_ack_done", 32'(m0_ack), 0);
    tick();
    chk("rd_s_cyc_idle", 32'(s_cyc), 0);

    // Simultaneous requests, four rounds.
    m0_addr = 32'hA0; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      chk($sformatf("both_grant%0d", i), s_addr, exp_grant_addr[i]);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
    end

    // Write pass-through from m1; m0 request mid-cycle must wait.
    m1_addr = 32'h2004; m1_wdata = 32'h12345678; m1_sel = 4'b0011; m1_we = 1;
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("wr_s_addr", s_addr, 32'h2004);
    chk("wr_s_wdata", s_wdata, 32'h12345678);
    chk("wr_s_sel", 32'(s_sel), 32'h3);
    chk("wr_s_we", 32'(s_we), 1);
    chk("wr_s_stb", 32'(s_stb), 1);
    m0_addr = 32'h500; m0_cyc = 1; m0_stb = 1;
    tick();
    s_ack = 1;
    #1;
    chk("wr_still_m1", s_addr, 32'h2004);
    chk("wr_m1_ack", 32'(m1_ack), 1);
    chk("wr_m0_ack", 32'(m0_ack), 0);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    chk("wr_idle_gap", 32'(s_cyc), 0);
    tick();
    chk("wr_m0_granted", s_addr, 32'h500);
    m0_cyc = 0; m0_stb = 0;
    tick();

    // Timeout: slave never acks m0.
    m0_addr = 32'h300; m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("to_no_err_c%0d", i), 32'(m0_err), 0);
      tick();
    end
    chk("to_err_c16", 32'(m0_err), 1);
    chk("to_ack_c16", 32'(m0_ack), 0);
    chk("to_s_cyc_c16", 32'(s_cyc), 1);
    tick();
    chk("to_drain_s_cyc", 32'(s_cyc), 0);
    chk("to_err_one_cycle", 32'(m0_err), 0);
    s_ack = 1;
    #1 chk("to_late_ack_dropped", 32'(m0_ack), 0);
    tick();
    s_ack = 0;
    tick();
    chk("to_drain_held", 32'(s_cyc), 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    m1_addr = 32'h700; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("to_back_to_idle", s_addr, 32'h700);
    m1_cyc = 0; m1_stb = 0;
    tick();

    // Ack exactly on the expiry cycle.
    m0_addr = 32'h400; m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 1; i <= 15; i++) tick();
    s_ack = 1;
    #1;
    chk("bd_ack", 32'(m0_ack), 1);
    chk("bd_no_err", 32'(m0_err), 0);
    tick();
    s_ack = 0;
    #1 chk("bd_no_drain", 32'(s_cyc), 1);
    m0_cyc = 0; m0_stb = 0;
    tick();

    // Reset mid-transfer while GNT1.
    m1_addr = 32'h800; m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1;
    #1 chk("rst_pre_m1_ack", 32'(m1_ack), 1);
    rst_n = 0;
    #1;
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_m1_ack", 32'(m1_ack), 0);
    chk("rst_m1_err", 32'(m1_err), 0);
    s_ack = 0;
    #1 rst_n = 1;
    m0_addr = 32'h900; m0_cyc = 1; m0_stb = 1;
    tick();
    chk("rst_first_grant", s_addr, 32'h800);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    chk("end_idle", 32'(s_cyc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
